// File: rtl/lcd_exibidor.sv
// HD44780 16x2 display stage: power-on init, then per request writes "mnemonic [rrrr]" and the signed result.
// Optional macro LCD_HEX_EN: line 2 shows "0x" + raw hex and the BCD conversion step is skipped.
module lcd_exibidor #(
  parameter int T_PWR_CICLOS = 750000,
  parameter int T_EN_CICLOS  = 25,
  parameter int T_CMD_CICLOS = 2500,
  parameter int T_CLR_CICLOS = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iniciar,
  input  logic [15:0] valor,
  input  logic [2:0]  opcode,
  input  logic [3:0]  reg_destino,
  output logic        ocupado,
  output logic        pronto,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on,
  output logic        lcd_blon
);
  localparam int MAX_A = (T_PWR_CICLOS > T_CLR_CICLOS) ? T_PWR_CICLOS : T_CLR_CICLOS;
  localparam int MAX_B = (T_CMD_CICLOS > T_EN_CICLOS) ? T_CMD_CICLOS : T_EN_CICLOS;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_C + 32);

  typedef enum logic [3:0] {
    ESPERA_PWR, INIT, OCIOSO, CONVERTE, LINHA1_CMD, LINHA1, LINHA2_CMD, LINHA2, FIM
  } estado_t;
  typedef enum logic [1:0] {F_LIVRE, F_PREP, F_EN, F_GAP} fase_t;

  estado_t       estado_q, estado_d;
  fase_t         fase_q, fase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [15:0]   valor_q, valor_d;
  logic [2:0]    opcode_q, opcode_d;
  logic [3:0]    reg_q, reg_d;
  logic [7:0]    lcd_data_q, lcd_data_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic          lcd_en_q, lcd_en_d;
  logic          ocupado_q, ocupado_d;
  logic          pronto_q, pronto_d;
  logic          lcd_on_q, lcd_on_d;
`ifndef LCD_HEX_EN
  logic [19:0]   bcd_q, bcd_d;
  logic [16:0]   bin_q, bin_d;
`endif

  function automatic logic [7:0] car_l1(input logic [3:0] i);
    logic [31:0] mn;
    logic [1:0]  k;
    logic [7:0]  c;
    case (opcode_q)
      3'd0:    mn = "LOAD";
      3'd1:    mn = "ADD ";
      3'd2:    mn = "ADDI";
      3'd3:    mn = "SUB ";
      3'd4:    mn = "SUBI";
      3'd5:    mn = "MUL ";
      3'd6:    mn = "CLR ";
      default: mn = "DPL ";
    endcase
    // positions 11..14 map to register bits 3..0
    k = 2'd2 - i[1:0];
    if (i < 4'd4)       c = mn[{~i[1:0], 3'b000} +: 8];
    else if (i < 4'd10) c = 8'h20;
    else if (i == 4'd10) c = 8'h5B;
    else if (i == 4'd15) c = 8'h5D;
    else                 c = {7'b0011000, reg_q[k]};
    return c;
  endfunction

  function automatic logic [7:0] car_l2(input logic [3:0] i);
    logic [7:0] c;
`ifdef LCD_HEX_EN
    logic [1:0] d;
    logic [3:0] nib;
    d   = 2'(4'd5 - i);
    nib = valor_q[{d, 2'b00} +: 4];
    if (i == 4'd0)      c = 8'h30;
    else if (i == 4'd1) c = 8'h78;
    else if (i <= 4'd5) c = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    else                c = 8'h20;
`else
    logic [2:0] d;
    d = 3'(4'd5 - i);
    if (i == 4'd0)      c = valor_q[15] ? 8'h2D : 8'h2B;
    else if (i <= 4'd5) c = {4'h3, bcd_q[{d, 2'b00} +: 4]};
    else                c = 8'h20;
`endif
    return c;
  endfunction

  // {rs, data} of the byte written at position idx of state st
  function automatic logic [8:0] byte_de(input estado_t st, input logic [3:0] idx);
    logic [8:0] b;
    case (st)
      INIT: begin
        case (idx[1:0])
          2'd0:    b = 9'h038;
          2'd1:    b = 9'h00C;
          2'd2:    b = 9'h001;
          default: b = 9'h006;
        endcase
      end
      LINHA1_CMD: b = 9'h080;
      LINHA2_CMD: b = 9'h0C0;
      LINHA1:     b = {1'b1, car_l1(idx)};
      LINHA2:     b = {1'b1, car_l2(idx)};
      default:    b = 9'h000;
    endcase
    return b;
  endfunction

  always_comb begin
    logic          fim_byte;
    logic          inicia;
    logic [CW-1:0] gap_fim;
`ifndef LCD_HEX_EN
    logic [16:0]   mag;
    logic [16:0]   src;
    logic [19:0]   adj;
`endif
    estado_d   = estado_q;
    fase_d     = fase_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    valor_d    = valor_q;
    opcode_d   = opcode_q;
    reg_d      = reg_q;
    lcd_data_d = lcd_data_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_en_d   = lcd_en_q;
    pronto_d   = 1'b0;
    lcd_on_d   = 1'b1;
    fim_byte   = 1'b0;
    inicia     = 1'b0;
    gap_fim    = (lcd_data_q == 8'h01 && !lcd_rs_q) ? CW'(T_CLR_CICLOS - 1) : CW'(T_CMD_CICLOS - 1);
`ifndef LCD_HEX_EN
    bcd_d = bcd_q;
    bin_d = bin_q;
    mag   = valor_q[15] ? (~{1'b1, valor_q} + 17'd1) : {1'b0, valor_q};
    // first double-dabble step starts from the fresh magnitude and an empty BCD register
    src   = (cnt_q == '0) ? mag : bin_q;
    adj   = (cnt_q == '0) ? 20'd0 : bcd_q;
    for (int k = 0; k < 5; k++)
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
`endif

    case (estado_q)
      ESPERA_PWR: begin
        if (cnt_q == CW'(T_PWR_CICLOS - 1)) begin
          estado_d = INIT;
          idx_d    = 4'd0;
          inicia   = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      OCIOSO: begin
        if (iniciar) begin
          valor_d  = valor;
          opcode_d = opcode;
          reg_d    = reg_destino;
`ifdef LCD_HEX_EN
          estado_d = LINHA1_CMD;
          inicia   = 1'b1;
`else
          estado_d = CONVERTE;
          cnt_d    = '0;
`endif
        end
      end
      CONVERTE: begin
`ifdef LCD_HEX_EN
        estado_d = OCIOSO;
`else
        {bcd_d, bin_d} = {adj, src} << 1;
        if (cnt_q == CW'(16)) begin
          estado_d = LINHA1_CMD;
          inicia   = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
`endif
      end
      FIM: estado_d = OCIOSO;
      default: begin
        case (fase_q)
          F_PREP: begin
            lcd_en_d = 1'b1;
            fase_d   = F_EN;
            cnt_d    = '0;
          end
          F_EN: begin
            if (cnt_q == CW'(T_EN_CICLOS - 1)) begin
              lcd_en_d = 1'b0;
              fase_d   = F_GAP;
              cnt_d    = '0;
            end else cnt_d = cnt_q + CW'(1);
          end
          F_GAP: begin
            if (cnt_q == gap_fim) fim_byte = 1'b1;
            else cnt_d = cnt_q + CW'(1);
          end
          default: fase_d = F_PREP;
        endcase
        if (fim_byte) begin
          fase_d = F_LIVRE;
          case (estado_q)
            INIT: begin
              if (idx_q == 4'd3) estado_d = OCIOSO;
              else begin idx_d = idx_q + 4'd1; inicia = 1'b1; end
            end
            LINHA1_CMD: begin estado_d = LINHA1; idx_d = 4'd0; inicia = 1'b1; end
            LINHA1: begin
              if (idx_q == 4'd15) estado_d = LINHA2_CMD;
              else idx_d = idx_q + 4'd1;
              inicia = 1'b1;
            end
            LINHA2_CMD: begin estado_d = LINHA2; idx_d = 4'd0; inicia = 1'b1; end
            default: begin
              if (idx_q == 4'd15) begin
                estado_d = FIM;
                pronto_d = 1'b1;
              end else begin
                idx_d  = idx_q + 4'd1;
                inicia = 1'b1;
              end
            end
          endcase
        end
      end
    endcase

    if (inicia) begin
      {lcd_rs_d, lcd_data_d} = byte_de(estado_d, idx_d);
      fase_d = F_PREP;
      cnt_d  = '0;
    end
    ocupado_d = (estado_d != OCIOSO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= ESPERA_PWR;
      fase_q     <= F_LIVRE;
      cnt_q      <= '0;
      idx_q      <= '0;
      valor_q    <= '0;
      opcode_q   <= '0;
      reg_q      <= '0;
      lcd_data_q <= '0;
      lcd_rs_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
      ocupado_q  <= 1'b1;
      pronto_q   <= 1'b0;
      lcd_on_q   <= 1'b0;
`ifndef LCD_HEX_EN
      bcd_q      <= '0;
      bin_q      <= '0;
`endif
    end else begin
      estado_q   <= estado_d;
      fase_q     <= fase_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      valor_q    <= valor_d;
      opcode_q   <= opcode_d;
      reg_q      <= reg_d;
      lcd_data_q <= lcd_data_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_en_q   <= lcd_en_d;
      ocupado_q  <= ocupado_d;
      pronto_q   <= pronto_d;
      lcd_on_q   <= lcd_on_d;
`ifndef LCD_HEX_EN
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
`endif
    end
  end

  assign ocupado  = ocupado_q;
  assign pronto   = pronto_q;
  assign lcd_data = lcd_data_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = lcd_en_q;
  assign lcd_on   = lcd_on_q;
  assign lcd_blon = lcd_on_q;
endmodule

// File: tb/tb_lcd_exibidor.sv
// Bench for lcd_exibidor: a bus monitor records every strobe; expected lines come from a string-level model.
`timescale 1ns/1ps

module tb_lcd_exibidor;
  localparam int TPWR = 20, TEN = 2, TCMD = 4, TCLR = 8;

  logic        clk = 1'b0, rst_n = 1'b0, iniciar = 1'b0;
  logic [15:0] valor = '0;
  logic [2:0]  opcode = '0;
  logic [3:0]  reg_destino = '0;
  logic        ocupado, pronto, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
  logic [7:0]  lcd_data;
  int          nassert = 0, nfail = 0;

  lcd_exibidor #(.T_PWR_CICLOS(TPWR), .T_EN_CICLOS(TEN), .T_CMD_CICLOS(TCMD), .T_CLR_CICLOS(TCLR)) dut (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .valor(valor), .opcode(opcode),
    .reg_destino(reg_destino), .ocupado(ocupado), .pronto(pronto), .lcd_data(lcd_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on), .lcd_blon(lcd_blon));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nassert++;
    if (obs !== exp) begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] dat;
    int         width;
    int         low;
    bit         stable;
    int         rise;
    int         fall;
  } strobe_t;
  strobe_t sq[$];

  int         cyc = 0, fall_cyc = 0, rise_cyc = 0, low_c = 0, pronto_n = 0, ocup_fall = 0;
  logic       en_p = 1'b0, ocup_p = 1'b1, rs_c = 1'b0, rs_p = 1'b0;
  logic [7:0] dat_c = '0, dat_p = '0;
  bit         stab = 1'b1;

  always @(negedge clk) begin
    strobe_t s;
    cyc++;
    if (!rst_n) begin
      en_p = 1'b0; ocup_p = 1'b1; fall_cyc = cyc;
    end else begin
      if (pronto) pronto_n++;
      if (ocup_p && !ocupado) ocup_fall = cyc;
      ocup_p = ocupado;
      if (lcd_en && !en_p) begin
        rise_cyc = cyc; low_c = cyc - fall_cyc; rs_c = lcd_rs; dat_c = lcd_data;
        stab = (dat_p == lcd_data) && (rs_p == lcd_rs);
      end else if (lcd_en && (lcd_data != dat_c || lcd_rs != rs_c)) stab = 1'b0;
      if (!lcd_en && en_p) begin
        fall_cyc = cyc;
        s.rs = rs_c; s.dat = dat_c; s.width = cyc - rise_cyc; s.low = low_c;
        s.stable = stab && (lcd_data == dat_c) && (lcd_rs == rs_c);
        s.rise = rise_cyc; s.fall = cyc;
        sq.push_back(s);
      end
      en_p = lcd_en; dat_p = lcd_data; rs_p = lcd_rs;
    end
  end

  function automatic logic [127:0] str2vec(input string s);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
    return v;
  endfunction

  function automatic logic [127:0] exp_l1(input logic [2:0] op, input logic [3:0] rd);
    string mn [8];
    mn = '{"LOAD", "ADD ", "ADDI", "SUB ", "SUBI", "MUL ", "CLR ", "DPL "};
    return str2vec($sformatf("%s      [%04b]", mn[op], rd));
  endfunction

  function automatic logic [127:0] exp_l2(input logic [15:0] v);
`ifdef LCD_HEX_EN
    string hx, t;
    hx = "0123456789ABCDEF";
    t = "0x";
    for (int i = 3; i >= 0; i--) t = $sformatf("%s%c", t, hx[int'((v >> (4*i)) & 16'hF)]);
    return str2vec(t);
`else
    int    sv, m;
    string sg;
    sv = int'($signed(v));
    if (sv < 0) begin sg = "-"; m = -sv; end
    else begin sg = "+"; m = sv; end
    return str2vec($sformatf("%s%05d", sg, m));
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ocupado !== 1'b0 && n < 3000) begin tick(); n++; end
    chk("idle_before_request", ocupado, 1'b0);
  endtask

  task automatic chk_init();
    int n = 0;
    while ((sq.size() < 4 || ocupado !== 1'b0) && n < 1000) begin tick(); n++; end
    chk("init_strobe_count", sq.size(), 4);
    if (sq.size() >= 4) begin
      chk("init_0x38", {sq[0].rs, sq[0].dat}, 9'h038);
      chk("init_0x0C", {sq[1].rs, sq[1].dat}, 9'h00C);
      chk("init_0x01", {sq[2].rs, sq[2].dat}, 9'h001);
      chk("init_0x06", {sq[3].rs, sq[3].dat}, 9'h006);
      chk("power_wait", sq[0].low, TPWR + 1);
      chk("gap_after_0x38", sq[1].low, TCMD + 1);
      chk("gap_after_0x0C", sq[2].low, TCMD + 1);
      chk("gap_after_clear", sq[3].low, TCLR + 1);
      chk("init_en_width", sq[0].width, TEN);
      chk("ocupado_after_last_gap", ocup_fall - sq[3].fall, TCMD);
    end
  endtask

  task automatic do_req(input logic [15:0] v, input logic [2:0] op, input logic [3:0] rd, input bit poke);
    int base, p0, c0, n, lat;
    logic [127:0] l1, l2;
    bit rsok, wok, lok, sok;
    wait_idle();
    base = sq.size(); p0 = pronto_n; c0 = cyc;
    valor = v; opcode = op; reg_destino = rd; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    valor = 16'($urandom); opcode = 3'($urandom); reg_destino = 4'($urandom);
    if (poke) begin
      n = 0;
      while (sq.size() < base + 4 && n < 2000) begin tick(); n++; end
      valor = ~v; opcode = op + 3'd1; reg_destino = ~rd; iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
    end
    n = 0;
    while (pronto_n == p0 && n < 4000) begin tick(); n++; end
    repeat (poke ? 40 : 3) tick();
    chk("pronto_pulses", pronto_n - p0, 1);
    chk("bytes_per_request", sq.size() - base, 34);
    chk("ocupado_after_done", ocupado, 1'b0);
    if (sq.size() >= base + 34) begin
      lat = sq[base].rise - c0;
`ifdef LCD_HEX_EN
      chk("no_convert_latency", lat, 2);
`else
      chk("convert_latency_bounded", (lat >= 3 && lat <= 22), 1'b1);
`endif
      chk("cmd_line1", {sq[base].rs, sq[base].dat}, 9'h080);
      chk("cmd_line2", {sq[base+17].rs, sq[base+17].dat}, 9'h0C0);
      rsok = 1'b1; wok = 1'b1; lok = 1'b1; sok = 1'b1;
      for (int i = 0; i < 16; i++) begin
        l1[127-8*i -: 8] = sq[base+1+i].dat;
        l2[127-8*i -: 8] = sq[base+18+i].dat;
        rsok &= sq[base+1+i].rs && sq[base+18+i].rs;
      end
      for (int i = 0; i < 34; i++) begin
        wok &= (sq[base+i].width == TEN);
        sok &= sq[base+i].stable;
        if (i > 0) lok &= (sq[base+i].low == TCMD + 1);
      end
      chk("line1_text", l1, exp_l1(op, rd));
      chk("line2_text", l2, exp_l2(v));
      chk("chars_rs_high", rsok, 1'b1);
      chk("en_width_all", wok, 1'b1);
      chk("gap_all", lok, 1'b1);
      chk("bus_stable", sok, 1'b1);
    end
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_ocupado", ocupado, 1'b1);
    chk("rst_pronto", pronto, 1'b0);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_rs", lcd_rs, 1'b0);
    chk("rst_rw", lcd_rw, 1'b0);
    chk("rst_en", lcd_en, 1'b0);
    chk("rst_on", lcd_on, 1'b0);
    chk("rst_blon", lcd_blon, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("power_on", lcd_on, 1'b1);
    chk("backlight_on", lcd_blon, 1'b1);
    chk_init();

    do_req(16'd37,   3'b001, 4'd5,  1'b0);
    do_req(16'h8000, 3'b011, 4'd12, 1'b0);
    do_req(16'hFFFF, 3'b110, 4'd15, 1'b0);
    do_req(16'h0000, 3'b000, 4'd0,  1'b0);
    do_req(16'h7FFF, 3'b111, 4'd10, 1'b0);
    do_req(16'hBEEF, 3'b010, 4'd9,  1'b0);
    do_req(16'd1234, 3'b100, 4'd3,  1'b1);
    for (int r = 0; r < 6; r++)
      do_req(16'($urandom), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b0);

    wait_idle();
    n = sq.size();
    valor = 16'd99; opcode = 3'b101; reg_destino = 4'd7; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    begin
      int k = 0;
      while (!(lcd_en === 1'b1 && sq.size() >= n + 5) && k < 2000) begin tick(); k++; end
    end
    chk("en_high_before_reset", lcd_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_en_drop", lcd_en, 1'b0);
    chk("async_ocupado", ocupado, 1'b1);
    chk("async_data", lcd_data, 8'h00);
    chk("async_on", lcd_on, 1'b0);
    tick();
    sq.delete();
    rst_n = 1'b1;
    chk_init();
    do_req(16'hFFF6, 3'b101, 4'd6, 1'b0);

    chk("rw_low_end", lcd_rw, 1'b0);
    chk("on_still_high", lcd_on, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
